// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver for 5-8 data bits, optional parity and 1 or 2 stop bits.
module uart_rx #(
   parameter int OSR = 16
) (
   input  logic       rx_clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [3:0] length,
   input  logic       parity_type,
   input  logic       parity_en,
   input  logic       stop2,
   output logic [7:0] rx_out,
   output logic       rx_done,
   output logic       rx_err,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);
   localparam int CW = $clog2(OSR);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic s1, rxs, rxs_d;
   logic [7:0] shift;
   logic [2:0] idx, last;
   logic pt_l, pen_l, s2_l, perr_w, ferr_w;
   logic half, full, fall, go, commit, exp_par;
   assign fall = rxs_d & ~rxs;
   assign half = cnt == CW'(OSR / 2 - 1);
   assign full = cnt == CW'(OSR - 1);
   assign go = state == START && half && !rxs;
   assign commit = (state == STOP1 || state == STOP2) && nxt == DONE;
   assign exp_par = pt_l ? ^shift : ~^shift;
   always_ff @(posedge rx_clk or negedge rst)
      if (!rst) {s1, rxs, rxs_d} <= 3'b111;
      else {s1, rxs, rxs_d} <= {rx, s1, rxs};
   always_ff @(posedge rx_clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = fall ? START : IDLE;
         START:   nxt = !half ? START : rxs ? IDLE : DATA;
         DATA:    nxt = !(full && idx == last) ? DATA : pen_l ? PARITY : STOP1;
         PARITY:  nxt = full ? STOP1 : PARITY;
         STOP1:   nxt = !full ? STOP1 : s2_l ? STOP2 : DONE;
         STOP2:   nxt = full ? DONE : STOP2;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      rx_done = state == DONE;
      rx_busy = state != IDLE;
      rx_err = parity_err | frame_err;
   end
   // Config is latched on a confirmed start bit so it cannot change mid-frame.
   always_ff @(posedge rx_clk or negedge rst)
      if (!rst) begin
         cnt <= '0;
         shift <= '0;
         idx <= '0;
         last <= 3'd7;
         pt_l <= 1'b0;
         pen_l <= 1'b0;
         s2_l <= 1'b0;
         perr_w <= 1'b0;
         ferr_w <= 1'b0;
         rx_out <= '0;
         parity_err <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cnt <= (state == IDLE || state == DONE || (state == START && half) || full) ? '0 : cnt + 1'b1;
         if (go) begin
            last <= (length >= 4'd5 && length <= 4'd8) ? 3'(length - 4'd1) : 3'd7;
            pt_l <= parity_type;
            pen_l <= parity_en;
            s2_l <= stop2;
            shift <= '0;
            idx <= '0;
            perr_w <= 1'b0;
            ferr_w <= 1'b0;
         end
         if (state == DATA && full) begin
            shift[idx] <= rxs;
            idx <= idx + 1'b1;
         end
         if (state == PARITY && full) perr_w <= rxs ^ exp_par;
         if ((state == STOP1 || state == STOP2) && full && !rxs) ferr_w <= 1'b1;
         if (commit) begin
            rx_out <= shift;
            parity_err <= perr_w;
            frame_err <= ferr_w | ~rxs;
         end
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level reference model.
module tb_uart_rx;
   localparam int OSR = 16;
   logic rx_clk = 1'b0, rst = 1'b0, rx = 1'b1;
   logic [3:0] length = 4'd8;
   logic parity_type = 1'b0, parity_en = 1'b0, stop2 = 1'b0;
   logic [7:0] rx_out;
   logic rx_done, rx_err, parity_err, frame_err, rx_busy;
   int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
   int dq_cyc[$];
   logic [7:0] dq_out[$];
   logic dq_perr[$], dq_ferr[$], dq_err[$];
   logic [7:0] last_out = 8'h00;
   logic last_perr = 1'b0, last_ferr = 1'b0;

   uart_rx #(.OSR(OSR)) dut (
      .rx_clk(rx_clk), .rst(rst), .rx(rx), .length(length), .parity_type(parity_type),
      .parity_en(parity_en), .stop2(stop2), .rx_out(rx_out), .rx_done(rx_done), .rx_err(rx_err),
      .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
   );

   always #5 rx_clk = ~rx_clk;
   always @(posedge rx_clk) cyc <= cyc + 1;
   always @(negedge rx_clk)
      if (rx_done) begin
         dq_cyc.push_back(cyc);
         dq_out.push_back(rx_out);
         dq_perr.push_back(parity_err);
         dq_ferr.push_back(frame_err);
         dq_err.push_back(rx_err);
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      dq_cyc.delete(); dq_out.delete(); dq_perr.delete(); dq_ferr.delete(); dq_err.delete();
   endtask

   // Frame-level model: what the receiver should report for a given line frame.
   function automatic void model(input logic [7:0] d, input logic [3:0] len, input logic pen, pt, pb,
                                 s2, st1, st2, output logic [7:0] eo, output logic ep, ef,
                                 output int f);
      int n;
      n = (len >= 5 && len <= 8) ? int'(len) : 8;
      eo = d & 8'((1 << n) - 1);
      ep = pen && (pb != (pt ? ^eo : ~^eo));
      ef = !st1 || (s2 && !st2);
      f = n + int'(pen) + 1 + int'(s2);
   endfunction

   // Called just after a negedge; returns just after a negedge with the line high.
   task automatic drive(input logic [7:0] d, input logic [3:0] len, input logic pen, pt, pb, s2,
                        st1, st2, scr);
      int n;
      n = (len >= 5 && len <= 8) ? int'(len) : 8;
      length = len; parity_en = pen; parity_type = pt; stop2 = s2;
      rx = 1'b0;
      start_cyc = cyc;
      repeat (OSR) @(negedge rx_clk);
      if (scr) begin
         length = 4'($urandom); parity_en = 1'($urandom); parity_type = 1'($urandom);
         stop2 = 1'($urandom);
      end
      for (int i = 0; i < n; i++) begin
         rx = d[i];
         repeat (OSR) @(negedge rx_clk);
      end
      if (pen) begin
         rx = pb;
         repeat (OSR) @(negedge rx_clk);
      end
      rx = st1;
      repeat (OSR) @(negedge rx_clk);
      if (s2) begin
         rx = st2;
         repeat (OSR) @(negedge rx_clk);
      end
      rx = 1'b1;
   endtask

   task automatic check_frame(input string tag, input logic [7:0] d, input logic [3:0] len,
                              input logic pen, pt, pb, s2, st1, st2, scr);
      logic [7:0] eo;
      logic ep, ef;
      int f;
      model(d, len, pen, pt, pb, s2, st1, st2, eo, ep, ef, f);
      clear_q();
      drive(d, len, pen, pt, pb, s2, st1, st2, scr);
      repeat (2) @(negedge rx_clk);
      chk({tag, "_pulses"}, dq_cyc.size(), 1);
      if (dq_cyc.size() > 0) begin
         chk({tag, "_cycle"}, dq_cyc[0], start_cyc + 2 + OSR / 2 + f * OSR + 1);
         chk({tag, "_out"}, dq_out[0], eo);
         chk({tag, "_perr"}, dq_perr[0], ep);
         chk({tag, "_ferr"}, dq_ferr[0], ef);
         chk({tag, "_err"}, dq_err[0], ep | ef);
      end
      chk({tag, "_busy_after"}, rx_busy, 0);
      last_out = eo; last_perr = ep; last_ferr = ef;
   endtask

   initial begin
      int c1, c2, c;
      repeat (3) @(negedge rx_clk);
      chk("rst_out", rx_out, 0);
      chk("rst_done", rx_done, 0);
      chk("rst_err", rx_err, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_busy", rx_busy, 0);
      rst = 1'b1;
      repeat (4) @(negedge rx_clk);
      check_frame("a5", 8'hA5, 4'd8, 0, 0, 0, 0, 1, 1, 0);
      check_frame("par_ok", 8'h16, 4'd5, 1, 1, 1, 0, 1, 1, 0);
      check_frame("par_bad", 8'h16, 4'd5, 1, 1, 0, 0, 1, 1, 0);
      check_frame("par_even", 8'h2B, 4'd6, 1, 0, 1, 0, 1, 1, 1);
      // Reset in the middle of the data bits must abort silently.
      clear_q();
      length = 4'd8; parity_en = 0; stop2 = 0;
      rx = 1'b0;
      repeat (OSR) @(negedge rx_clk);
      rx = 1'b1;
      repeat (2 * OSR + 3) @(negedge rx_clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_out", rx_out, 0);
      chk("mid_rst_perr", parity_err, 0);
      chk("mid_rst_err", rx_err, 0);
      chk("mid_rst_busy", rx_busy, 0);
      repeat (3) @(negedge rx_clk);
      rst = 1'b1;
      repeat (12 * OSR) @(negedge rx_clk);
      chk("mid_rst_no_done", dq_cyc.size(), 0);
      check_frame("after_rst", 8'h3C, 4'd8, 0, 0, 0, 0, 1, 1, 0);
      check_frame("stop2_bad", 8'h5A, 4'd7, 0, 0, 0, 1, 1, 0, 0);
      check_frame("stop2_ok", 8'h25, 4'd7, 0, 0, 0, 1, 1, 1, 0);
      // Short low glitch on an idle line is rejected at the mid-start sample.
      clear_q();
      rx = 1'b0;
      c = cyc;
      repeat (3) @(negedge rx_clk);
      chk("glitch_busy", rx_busy, 1);
      repeat (2) @(negedge rx_clk);
      rx = 1'b1;
      while (cyc < c + 2 + OSR / 2 + 1) @(negedge rx_clk);
      chk("glitch_idle", rx_busy, 0);
      repeat (2 * OSR) @(negedge rx_clk);
      chk("glitch_no_done", dq_cyc.size(), 0);
      chk("glitch_out", rx_out, last_out);
      chk("glitch_ferr", frame_err, last_ferr);
      chk("glitch_perr", parity_err, last_perr);
      // Back-to-back frames followed directly by a break.
      clear_q();
      drive(8'h55, 4'd8, 0, 0, 0, 0, 1, 1, 0);
      c1 = start_cyc;
      drive(8'hFF, 4'd8, 0, 0, 0, 0, 1, 1, 0);
      c2 = start_cyc;
      rx = 1'b0;
      c = cyc;
      repeat (12 * OSR) @(negedge rx_clk);
      chk("b2b_pulses", dq_cyc.size(), 3);
      if (dq_cyc.size() == 3) begin
         chk("b2b0_cycle", dq_cyc[0], c1 + 2 + OSR / 2 + 9 * OSR + 1);
         chk("b2b0_out", dq_out[0], 8'h55);
         chk("b2b0_ferr", dq_ferr[0], 0);
         chk("b2b1_cycle", dq_cyc[1], c2 + 2 + OSR / 2 + 9 * OSR + 1);
         chk("b2b1_out", dq_out[1], 8'hFF);
         chk("b2b1_err", dq_err[1], 0);
         chk("brk_cycle", dq_cyc[2], c + 2 + OSR / 2 + 9 * OSR + 1);
         chk("brk_out", dq_out[2], 8'h00);
         chk("brk_ferr", dq_ferr[2], 1);
         chk("brk_perr", dq_perr[2], 0);
      end
      repeat (10 * OSR) @(negedge rx_clk);
      chk("brk_no_retrigger", dq_cyc.size(), 3);
      chk("brk_busy", rx_busy, 0);
      rx = 1'b1;
      repeat (OSR) @(negedge rx_clk);
      chk("brk_release", dq_cyc.size(), 3);
      check_frame("post_brk", 8'hC3, 4'd8, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 12; i++)
         check_frame($sformatf("rnd%0d", i), 8'($urandom), 4'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0, 1'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
